// File: rtl/link_packet_filter.sv
// Service-protocol packet receiver. Frames SPI words into packets, checks the checksum,
// and commits send-data payloads into a FIFO that can be rolled back.
module link_packet_filter #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ADDR_BASE = 'hAB,
  parameter int unsigned CMD_SEND  = 'hA2,
  localparam int unsigned HW       = DATA_W / 2,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned PW       = AW + 1
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              frame,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  input  logic              out_ready,
  output logic              pkt_ok,
  output logic              pkt_err,
  output logic [1:0]        err_code,
  output logic [HW-1:0]     cmd_code,
  output logic [CH_W-1:0]   cmd_ch,
  output logic [HW-1:0]     cmd_size,
  output logic [PW-1:0]     fifo_count
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_HDR, S_DATA, S_CSUM, S_DONE} state_t;
  typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_CSUM = 2'd1, ERR_OVF = 2'd2, ERR_ABORT = 2'd3} err_t;

  localparam logic [HW-1:0] ADDR_BASE_H = HW'(ADDR_BASE);
  localparam logic [HW-1:0] CMD_SEND_H  = HW'(CMD_SEND);
  localparam logic [HW-1:0] NUM_CH_H    = HW'(NUM_CH);

  state_t state, state_next;

  logic              frame_q;
  logic [CH_W-1:0]   ch_q;
  logic [HW-1:0]     cmd_q, size_q, remain_q;
  logic [DATA_W-1:0] sum_q;
  logic              ovf_q;
  logic [PW-1:0]     wr_ptr_c, wr_ptr_t, rd_ptr;
  logic [CH_W+DATA_W-1:0] mem [DEPTH];

  logic [HW-1:0] word_hi, word_lo, addr_off;
  logic          addr_hit, ovf_hdr, pop;
  logic          addr_take, hdr_take, data_take, csum_take, abort;
  logic          ok_set, err_set, do_write;
  err_t          err_val;

  assign word_hi  = in_data[DATA_W-1:HW];
  assign word_lo  = in_data[HW-1:0];
  assign addr_off = word_hi - ADDR_BASE_H;
  assign addr_hit = addr_off < NUM_CH_H;
  // Free space is judged against committed words only; pops during the packet only add room.
  assign ovf_hdr  = (word_lo == CMD_SEND_H) && (32'(word_hi) > (DEPTH - 32'(fifo_count)));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (frame && !frame_q) state_next = S_ADDR;
      S_ADDR: begin
        if (!frame)        state_next = S_IDLE;
        else if (in_valid) state_next = addr_hit ? S_HDR : S_DONE;
      end
      S_HDR: begin
        if (!frame)        state_next = S_IDLE;
        else if (in_valid) state_next = (word_hi == '0) ? S_CSUM : S_DATA;
      end
      S_DATA: begin
        if (!frame)                                 state_next = S_IDLE;
        else if (in_valid && remain_q == HW'(1))    state_next = S_CSUM;
      end
      S_CSUM: begin
        if (!frame)        state_next = S_IDLE;
        else if (in_valid) state_next = S_DONE;
      end
      S_DONE:  if (!frame) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    addr_take = 1'b0;
    hdr_take  = 1'b0;
    data_take = 1'b0;
    csum_take = 1'b0;
    abort     = 1'b0;
    case (state)
      S_ADDR: addr_take = frame && in_valid;
      S_HDR:  begin abort = !frame; hdr_take  = frame && in_valid; end
      S_DATA: begin abort = !frame; data_take = frame && in_valid; end
      S_CSUM: begin abort = !frame; csum_take = frame && in_valid; end
      default: ;
    endcase
    ok_set   = csum_take && !ovf_q && (in_data == sum_q);
    err_set  = abort || (csum_take && !ok_set);
    err_val  = abort ? ERR_ABORT : (ovf_q ? ERR_OVF : ERR_CSUM);
    do_write = data_take && (cmd_q == CMD_SEND_H) && !ovf_q;
  end

  assign out_valid  = (wr_ptr_c != rd_ptr);
  assign pop        = out_valid && out_ready;
  assign fifo_count = wr_ptr_c - rd_ptr;
  assign {out_ch, out_data} = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      frame_q  <= 1'b0;
      ch_q     <= '0;
      cmd_q    <= '0;
      size_q   <= '0;
      remain_q <= '0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_c <= '0;
      wr_ptr_t <= '0;
      rd_ptr   <= '0;
      pkt_ok   <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= '0;
      cmd_code <= '0;
      cmd_ch   <= '0;
      cmd_size <= '0;
    end else begin
      frame_q <= frame;
      pkt_ok  <= ok_set;
      pkt_err <= err_set;

      if (addr_take) begin
        ch_q  <= addr_off[CH_W-1:0];
        sum_q <= in_data;
      end
      if (hdr_take) begin
        cmd_q    <= word_lo;
        size_q   <= word_hi;
        remain_q <= word_hi;
        sum_q    <= sum_q + in_data;
        ovf_q    <= ovf_hdr;
      end
      if (data_take) begin
        sum_q    <= sum_q + in_data;
        remain_q <= remain_q - HW'(1);
      end
      if (do_write) wr_ptr_t <= wr_ptr_t + PW'(1);

      // Resolution: commit publishes the tentative words, any error discards them.
      if (ok_set) begin
        wr_ptr_c <= wr_ptr_t;
        cmd_code <= cmd_q;
        cmd_ch   <= ch_q;
        cmd_size <= size_q;
      end
      if (err_set) begin
        wr_ptr_t <= wr_ptr_c;
        err_code <= err_val;
      end

      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // NOTE: payload storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_t[AW-1:0]] <= {ch_q, in_data};
  end

endmodule

// File: tb/tb_link_packet_filter.sv
// Bench for link_packet_filter (DEPTH=4): directed packet table, corner sequences and
// random packets, all checked cycle by cycle against a packet-level queue model.
module tb_link_packet_filter;

  localparam int DEPTH  = 4;
  localparam int NUM_CH = 2;

  logic        clk = 1'b0;
  logic        nRst;
  logic        frame, in_valid, out_ready;
  logic [15:0] in_data;
  logic        out_valid, pkt_ok, pkt_err;
  logic [15:0] out_data;
  logic [0:0]  out_ch, cmd_ch;
  logic [1:0]  err_code;
  logic [7:0]  cmd_code, cmd_size;
  logic [2:0]  fifo_count;

  link_packet_filter #(
    .DATA_W(16), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .ADDR_BASE('hAB), .CMD_SEND('hA2)
  ) dut (
    .clk(clk), .nRst(nRst), .frame(frame), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready),
    .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_code(err_code), .cmd_code(cmd_code),
    .cmd_ch(cmd_ch), .cmd_size(cmd_size), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level reference model: committed and pending payloads as queues.
  typedef struct packed { logic ch; logic [15:0] d; } ent_t;
  ent_t        q[$], pend[$];
  logic [15:0] pkt[$];
  bit          m_coll, m_done, m_fprev, m_ovf;
  int          m_size;
  logic [7:0]  m_cmd;
  logic        m_ch;
  bit          e_ok, e_err;
  logic [1:0]  e_code;
  logic [7:0]  e_cmd, e_size;
  logic        e_cmdch;
  bit          saw_ok, saw_err;
  logic [1:0]  saw_code;

  function automatic void model_reset();
    q.delete(); pend.delete(); pkt.delete();
    m_coll = 0; m_done = 0; m_fprev = 0; m_ovf = 0; m_size = 0; m_cmd = 0; m_ch = 0;
    e_ok = 0; e_err = 0; e_code = 0; e_cmd = 0; e_size = 0; e_cmdch = 0;
  endfunction

  function automatic void model_edge(input logic f, input logic v, input logic [15:0] d, input logic r);
    int          cnt0;
    bit          do_pop;
    logic [7:0]  off;
    logic [15:0] s;
    cnt0   = q.size();
    do_pop = r && (cnt0 > 0);
    e_ok   = 0;
    e_err  = 0;
    if (m_done) begin
      if (!f) m_done = 0;
    end else if (m_coll) begin
      if (!f) begin
        if (pkt.size() > 0) begin e_err = 1; e_code = 2'd3; end
        pend.delete();
        m_coll = 0;
      end else if (v) begin
        pkt.push_back(d);
        if (pkt.size() == 1) begin
          off = d[15:8] - 8'hAB;
          if (off < NUM_CH) m_ch = off[0];
          else begin m_coll = 0; m_done = 1; end
        end else if (pkt.size() == 2) begin
          m_size = int'(d[15:8]);
          m_cmd  = d[7:0];
          m_ovf  = (m_cmd == 8'hA2) && (m_size > DEPTH - cnt0);
        end else if (pkt.size() <= m_size + 2) begin
          if (m_cmd == 8'hA2 && !m_ovf) pend.push_back({m_ch, d});
        end else begin
          s = 16'h0;
          for (int i = 0; i < pkt.size() - 1; i++) s = s + pkt[i];
          if (m_ovf) begin
            e_err = 1; e_code = 2'd2;
          end else if (s != d) begin
            e_err = 1; e_code = 2'd1;
          end else begin
            e_ok = 1;
            foreach (pend[k]) q.push_back(pend[k]);
            e_cmd = m_cmd; e_size = 8'(m_size); e_cmdch = m_ch;
          end
          pend.delete();
          m_coll = 0;
          m_done = 1;
        end
      end
    end else if (f && !m_fprev) begin
      m_coll = 1;
      pkt.delete();
    end
    m_fprev = f;
    if (do_pop) void'(q.pop_front());
  endfunction

  task automatic compare_outputs();
    check("pkt_ok", pkt_ok, e_ok);
    check("pkt_err", pkt_err, e_err);
    check("err_code", err_code, e_code);
    check("cmd_code", cmd_code, e_cmd);
    check("cmd_ch", cmd_ch, e_cmdch);
    check("cmd_size", cmd_size, e_size);
    check("fifo_count", fifo_count, q.size());
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_data", out_data, q[0].d);
      check("out_ch", out_ch, q[0].ch);
    end
  endtask

  task automatic step(input logic f, input logic v, input logic [15:0] d, input logic r);
    frame = f; in_valid = v; in_data = d; out_ready = r;
    model_edge(f, v, d, r);
    @(posedge clk);
    #1;
    compare_outputs();
    if (pkt_ok) saw_ok = 1'b1;
    if (pkt_err) begin saw_err = 1'b1; saw_code = err_code; end
  endtask

  task automatic apply_reset();
    nRst = 1'b0; frame = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("reset fifo_count", fifo_count, 0);
    check("reset out_valid", out_valid, 0);
    check("reset pkt_ok", pkt_ok, 0);
    check("reset pkt_err", pkt_err, 0);
    check("reset err_code", err_code, 0);
    check("reset cmd_code", cmd_code, 0);
    check("reset cmd_size", cmd_size, 0);
    nRst = 1'b1;
  endtask

  typedef struct packed {
    logic [0:7][15:0] w;
    logic [3:0]       n;
    logic             ok;
    logic             err;
    logic [1:0]       code;
    logic [2:0]       cnt;
    logic             drain;
  } vec_t;

  function automatic vec_t mk(input logic [0:7][15:0] w, input int n, input bit ok, input bit err,
                              input logic [1:0] code, input int cnt, input bit drain);
    vec_t t;
    t.w = w; t.n = 4'(n); t.ok = ok; t.err = err; t.code = code; t.cnt = 3'(cnt); t.drain = drain;
    return t;
  endfunction

  task automatic send_words(input logic [0:7][15:0] w, input int n, input logic r);
    step(1, 0, '0, r);
    for (int k = 0; k < n; k++) step(1, 1, w[k], r);
    step(1, 0, '0, r);
    step(0, 0, '0, r);
    step(0, 0, '0, r);
  endtask

  task automatic drain();
    repeat (6) step(0, 0, '0, 1);
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = mk({16'hAB00, 16'h02A2, 16'h1111, 16'h2222, 16'hE0D5, 48'h0}, 5, 1, 0, 0, 2, 1);
    vecs[1]  = mk({16'hAB00, 16'h02A2, 16'h1111, 16'h2222, 16'hE0D0, 48'h0}, 5, 0, 1, 1, 0, 0);
    vecs[2]  = mk({16'hAC00, 16'h00B0, 16'hACB0, 80'h0}, 3, 1, 0, 0, 0, 0);
    vecs[3]  = mk({16'hAC00, 16'h00B0, 16'hACB0, 16'hAB00, 16'h00B0, 16'hABB0, 32'h0}, 6, 1, 0, 0, 0, 0);
    vecs[4]  = mk({16'h0100, 16'h00A0, 16'h01A0, 80'h0}, 3, 0, 0, 0, 0, 0);
    vecs[5]  = mk({16'hAB00, 16'h05A2, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'hB0B1},
                  8, 0, 1, 2, 0, 0);
    vecs[6]  = mk({16'hAB00, 16'h03A2, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'hCFC3, 32'h0}, 6, 1, 0, 0, 3, 0);
    vecs[7]  = mk({16'hAC00, 16'h02A2, 16'h0001, 16'h0002, 16'hAEA5, 48'h0}, 5, 0, 1, 2, 3, 1);
    vecs[8]  = mk({16'hAB00, 16'h03A2, 16'h0001, 80'h0}, 3, 0, 1, 3, 0, 0);
    vecs[9]  = mk({16'hAB00, 16'h03A2, 16'h0D0D, 16'h0E0E, 16'h0F0F, 16'hD8CC, 32'h0}, 6, 1, 0, 0, 3, 1);
    vecs[10] = mk({16'hAB00, 16'h04A2, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hAFAC, 16'h0},
                  7, 1, 0, 0, 4, 1);
    vecs[11] = mk({16'hAC00, 16'h01A2, 16'hFFFF, 16'hADA1, 64'h0}, 4, 1, 0, 0, 1, 1);
    vecs[12] = mk({16'hAB00, 16'h00A2, 16'hABA2, 80'h0}, 3, 1, 0, 0, 0, 0);

    apply_reset();

    for (int i = 0; i < 13; i++) begin
      saw_ok = 0; saw_err = 0; saw_code = 0;
      send_words(vecs[i].w, int'(vecs[i].n), 1'b0);
      check($sformatf("vec%0d ok", i), saw_ok, vecs[i].ok);
      check($sformatf("vec%0d err", i), saw_err, vecs[i].err);
      if (vecs[i].err) check($sformatf("vec%0d code", i), saw_code, vecs[i].code);
      check($sformatf("vec%0d count", i), fifo_count, vecs[i].cnt);
      if (vecs[i].drain) drain();
    end

    // Pop of the head on the same edge that commits a new word.
    send_words({16'hAB00, 16'h01A2, 16'h7777, 16'h2419, 64'h0}, 4, 1'b0);
    step(1, 0, '0, 0);
    step(1, 1, 16'hAB00, 0);
    step(1, 1, 16'h01A2, 0);
    step(1, 1, 16'h8888, 0);
    step(1, 1, 16'h352A, 1);
    check("pop+commit count", fifo_count, 1);
    check("pop+commit head", out_data, 16'h8888);
    step(1, 0, '0, 0);
    step(0, 0, '0, 0);
    drain();

    // Reset in the middle of a packet discards committed and pending words.
    send_words({16'hAB00, 16'h01A2, 16'h5555, 16'h01F7, 64'h0}, 4, 1'b0);
    check("pre-reset count", fifo_count, 1);
    step(1, 0, '0, 0);
    step(1, 1, 16'hAB00, 0);
    step(1, 1, 16'h02A2, 0);
    step(1, 1, 16'h1234, 0);
    apply_reset();
    saw_ok = 0;
    send_words({16'hAB00, 16'h02A2, 16'h1111, 16'h2222, 16'hE0D5, 48'h0}, 5, 1'b0);
    check("post-reset ok", saw_ok, 1);
    check("post-reset count", fifo_count, 2);
    drain();

    // Random packets against the model.
    for (int p = 0; p < 300; p++) begin
      logic [15:0] ws[$];
      logic [7:0]  a, c, sz;
      logic [15:0] s;
      int          nsend;
      ws.delete();
      case ($urandom_range(0, 9))
        0:       a = 8'h01;
        1:       a = 8'hAD;
        default: a = 8'hAB + 8'($urandom_range(0, 1));
      endcase
      c  = ($urandom_range(0, 3) == 0) ? 8'hB0 : 8'hA2;
      sz = 8'($urandom_range(0, 5));
      ws.push_back({a, 8'h00});
      ws.push_back({sz, c});
      for (int k = 0; k < int'(sz); k++) ws.push_back(16'($urandom));
      s = 16'h0;
      foreach (ws[k]) s = s + ws[k];
      if ($urandom_range(0, 5) == 0) s = s ^ 16'h0100;
      ws.push_back(s);
      if ($urandom_range(0, 7) == 0) ws.push_back(16'($urandom));
      nsend = ws.size();
      if ($urandom_range(0, 9) == 0) nsend = $urandom_range(1, ws.size() - 1);
      step(1, 0, '0, 1'($urandom_range(0, 1)));
      for (int k = 0; k < nsend; k++) begin
        if ($urandom_range(0, 3) == 0) step(1, 0, 16'($urandom), 1'($urandom_range(0, 1)));
        step(1, 1, ws[k], 1'($urandom_range(0, 1)));
      end
      step(1, 0, '0, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 3)) step(0, 0, '0, 1'($urandom_range(0, 1)));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
